// File: rtl/avalon_ahb_bridge_if.sv
// Bus bundle for the Avalon-MM slave / AHB master bridge. The bridge takes the
// slave modport and the local Avalon master plus AHB slave take the master modport.
interface avalon_ahb_bridge_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic        waitrequest;
    logic        readdatavalid;
    logic [31:0] readdata;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;

    logic        err_clr;
    logic        err_sticky;

    modport slave (
        input  address, read, write, writedata, HRDATA, HREADY, HRESP, err_clr,
        output waitrequest, readdatavalid, readdata,
               HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, err_sticky
    );

    modport master (
        output address, read, write, writedata, HRDATA, HREADY, HRESP, err_clr,
        input  waitrequest, readdatavalid, readdata,
               HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, err_sticky
    );
endinterface

// File: rtl/avalon_ahb_bridge.sv
// Avalon-MM slave to AHB master bridge: single 32-bit transfers, one outstanding,
// RETRY/SPLIT re-issued up to RETRY_LIMIT times before being reported as ERROR.
module avalon_ahb_bridge #(
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF,
    parameter logic [3:0]  HPROT_VAL   = 4'b0011,
    parameter int          RETRY_LIMIT = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    avalon_ahb_bridge_if.slave  bus
);
    localparam int CNT_W = $clog2(RETRY_LIMIT + 2);
    localparam logic [CNT_W-1:0] RETRY_MAX = CNT_W'(RETRY_LIMIT);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t           state_reg, state_next;
    logic [31:0]      addr_reg, addr_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic [31:0]      rdata_reg, rdata_next;
    logic             write_reg, write_next;
    logic             err_reg, err_next;
    logic [CNT_W-1:0] retry_reg, retry_next;
    logic             xfer_err;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            write_reg <= 1'b0;
            err_reg   <= 1'b0;
            retry_reg <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            write_reg <= write_next;
            err_reg   <= err_next;
            retry_reg <= retry_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        write_next = write_reg;
        retry_next = retry_reg;
        xfer_err   = 1'b0;
        err_next   = bus.err_clr ? 1'b0 : err_reg;

        case (state_reg)
            S_IDLE: begin
                if (bus.read || bus.write) begin
                    addr_next  = bus.address;
                    wdata_next = bus.writedata;
                    write_next = bus.write;
                    retry_next = '0;
                    state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus.HREADY) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.HREADY) begin
                    if (bus.HRESP == HRESP_OKAY) begin
                        if (write_reg) begin
                            state_next = S_IDLE;
                        end else begin
                            rdata_next = bus.HRDATA;
                            state_next = S_RESP;
                        end
                    end else if (bus.HRESP == HRESP_ERROR || retry_reg == RETRY_MAX) begin
                        xfer_err = 1'b1;
                    end else begin
                        retry_next = retry_reg + 1'b1;
                        state_next = S_ADDR;
                    end
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Exhausted retries land here too; setting the flag beats a same-cycle clear.
        if (xfer_err) begin
            err_next = 1'b1;
            if (write_reg) begin
                state_next = S_IDLE;
            end else begin
                rdata_next = ERR_DATA;
                state_next = S_RESP;
            end
        end
    end

    assign bus.waitrequest   = !reset_n || (state_reg != S_IDLE);
    assign bus.readdatavalid = (state_reg == S_RESP);
    assign bus.readdata      = rdata_reg;
    assign bus.HADDR         = addr_reg;
    assign bus.HTRANS        = (state_reg == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HWRITE        = write_reg;
    assign bus.HSIZE         = 3'b010;
    assign bus.HBURST        = 3'b000;
    assign bus.HPROT         = HPROT_VAL;
    assign bus.HWDATA        = wdata_reg;
    assign bus.err_sticky    = err_reg;
endmodule

// File: tb/tb_avalon_ahb_bridge.sv
// Directed testbench for avalon_ahb_bridge: the bench acts as both the Avalon
// master and the AHB slave, sampling and driving on the falling clock edge.
module tb_avalon_ahb_bridge;
    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   issues;

    avalon_ahb_bridge_if bus ();

    avalon_ahb_bridge dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts at a falling edge with the bridge idle; ends at a falling edge back in idle.
    task automatic run_write(input logic [31:0] a, input logic [31:0] d, input int n_retry,
                             input logic [1:0] rresp, output int n_issue);
        int dphase;
        n_issue = 0;
        dphase  = 0;
        bus.write     = 1'b1;
        bus.address   = a;
        bus.writedata = d;
        @(negedge clk);
        bus.write = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.waitrequest) break;
            if (bus.HTRANS == 2'b10) begin
                n_issue++;
                check("rw_haddr", bus.HADDR, a);
                check("rw_hwrite", 32'(bus.HWRITE), 32'd1);
            end else begin
                check("rw_hwdata", bus.HWDATA, d);
                bus.HREADY = 1'b1;
                bus.HRESP  = (dphase < n_retry) ? rresp : 2'b00;
                dphase++;
            end
            @(negedge clk);
        end
        bus.HRESP = 2'b00;
        check("rw_done_idle", 32'(bus.waitrequest), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        bus.address   = '0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = '0;
        bus.HRDATA    = '0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 2'b00;
        bus.err_clr   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_wait", 32'(bus.waitrequest), 32'd1);
        check("rst_htrans", 32'(bus.HTRANS), 32'd0);
        check("rst_hwrite", 32'(bus.HWRITE), 32'd0);
        check("rst_haddr", bus.HADDR, 32'd0);
        check("rst_hwdata", bus.HWDATA, 32'd0);
        check("rst_rdv", 32'(bus.readdatavalid), 32'd0);
        check("rst_rdata", bus.readdata, 32'd0);
        check("rst_err", 32'(bus.err_sticky), 32'd0);
        check("rst_hsize", 32'(bus.HSIZE), 32'd2);
        check("rst_hburst", 32'(bus.HBURST), 32'd0);
        check("rst_hprot", 32'(bus.HPROT), 32'd3);
        reset_n = 1'b1;
        $display("[TB] txn reset");

        // 1: zero-wait write
        @(negedge clk);
        check("t1_idle_wait", 32'(bus.waitrequest), 32'd0);
        bus.write = 1'b1; bus.address = 32'h1000; bus.writedata = 32'hCAFEF00D;
        @(negedge clk);
        bus.write = 1'b0;
        check("t1_addr_htrans", 32'(bus.HTRANS), 32'd2);
        check("t1_addr_haddr", bus.HADDR, 32'h1000);
        check("t1_addr_hwrite", 32'(bus.HWRITE), 32'd1);
        check("t1_addr_wait", 32'(bus.waitrequest), 32'd1);
        @(negedge clk);
        check("t1_data_htrans", 32'(bus.HTRANS), 32'd0);
        check("t1_data_hwdata", bus.HWDATA, 32'hCAFEF00D);
        check("t1_data_wait", 32'(bus.waitrequest), 32'd1);
        @(negedge clk);
        check("t1_idle_again", 32'(bus.waitrequest), 32'd0);
        check("t1_rdv", 32'(bus.readdatavalid), 32'd0);
        $display("[TB] txn write 0x1000 = 0xcafef00d");

        // 2: read with three wait states
        bus.read = 1'b1; bus.address = 32'h2004;
        @(negedge clk);
        bus.read = 1'b0;
        check("t2_addr_htrans", 32'(bus.HTRANS), 32'd2);
        check("t2_addr_haddr", bus.HADDR, 32'h2004);
        check("t2_addr_hwrite", 32'(bus.HWRITE), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_ws_wait", 32'(bus.waitrequest), 32'd1);
            check("t2_ws_rdv", 32'(bus.readdatavalid), 32'd0);
            bus.HREADY = 1'b0;
        end
        @(negedge clk);
        check("t2_last_htrans", 32'(bus.HTRANS), 32'd0);
        bus.HREADY = 1'b1; bus.HRDATA = 32'h12345678;
        @(negedge clk);
        bus.HRDATA = '0;
        check("t2_resp_rdv", 32'(bus.readdatavalid), 32'd1);
        check("t2_resp_rdata", bus.readdata, 32'h12345678);
        check("t2_resp_wait", 32'(bus.waitrequest), 32'd1);
        @(negedge clk);
        check("t2_post_rdv", 32'(bus.readdatavalid), 32'd0);
        check("t2_post_rdata", bus.readdata, 32'h12345678);
        check("t2_post_wait", 32'(bus.waitrequest), 32'd0);
        $display("[TB] txn read 0x2004 -> 0x%h", bus.readdata);

        // 3: read with two-cycle ERROR, then err_clr
        bus.read = 1'b1; bus.address = 32'h3000;
        @(negedge clk);
        bus.read = 1'b0;
        @(negedge clk);
        check("t3_d1_htrans", 32'(bus.HTRANS), 32'd0);
        bus.HREADY = 1'b0; bus.HRESP = 2'b01;
        @(negedge clk);
        check("t3_d2_wait", 32'(bus.waitrequest), 32'd1);
        check("t3_d2_err", 32'(bus.err_sticky), 32'd0);
        bus.HREADY = 1'b1; bus.HRESP = 2'b01; bus.HRDATA = 32'h5555_AAAA;
        @(negedge clk);
        bus.HRESP = 2'b00; bus.HRDATA = '0;
        check("t3_resp_rdv", 32'(bus.readdatavalid), 32'd1);
        check("t3_resp_rdata", bus.readdata, 32'hDEADBEEF);
        check("t3_resp_err", 32'(bus.err_sticky), 32'd1);
        @(negedge clk);
        check("t3_idle_err", 32'(bus.err_sticky), 32'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check("t3_clr_err", 32'(bus.err_sticky), 32'd0);
        $display("[TB] txn read 0x3000 error -> 0x%h", bus.readdata);

        // 4: write retried twice then OKAY
        run_write(32'h4000, 32'hA5A55A5A, 2, 2'b10, issues);
        check("t4_issues", 32'(issues), 32'd3);
        check("t4_err", 32'(bus.err_sticky), 32'd0);
        $display("[TB] txn write 0x4000 retry x2, %0d issues", issues);

        // 5: SPLIT forever -> ERROR after 15 re-issues
        run_write(32'h7000, 32'hBEEF0001, 1000, 2'b11, issues);
        check("t5_issues", 32'(issues), 32'd16);
        check("t5_err", 32'(bus.err_sticky), 32'd1);
        $display("[TB] txn write 0x7000 split forever, %0d issues", issues);

        // 7: read and write together -> write wins
        bus.read = 1'b1; bus.write = 1'b1; bus.address = 32'h6000; bus.writedata = 32'h0000_0011;
        @(negedge clk);
        bus.read = 1'b0; bus.write = 1'b0;
        check("t7_hwrite", 32'(bus.HWRITE), 32'd1);
        @(negedge clk);
        check("t7_hwdata", bus.HWDATA, 32'h11);
        @(negedge clk);
        check("t7_idle", 32'(bus.waitrequest), 32'd0);
        check("t7_rdv", 32'(bus.readdatavalid), 32'd0);
        $display("[TB] txn read+write 0x6000 as write");

        // 6: reset during the data phase of a read
        bus.read = 1'b1; bus.address = 32'h5000;
        @(negedge clk);
        bus.read = 1'b0;
        check("t6_addr_htrans", 32'(bus.HTRANS), 32'd2);
        @(negedge clk);
        bus.HREADY = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        check("t6_rst_htrans", 32'(bus.HTRANS), 32'd0);
        check("t6_rst_rdv", 32'(bus.readdatavalid), 32'd0);
        check("t6_rst_wait", 32'(bus.waitrequest), 32'd1);
        check("t6_rst_err", 32'(bus.err_sticky), 32'd0);
        reset_n = 1'b1; bus.HREADY = 1'b1; bus.HRDATA = 32'h77;
        @(negedge clk);
        check("t6_rel_wait", 32'(bus.waitrequest), 32'd0);
        check("t6_rel_rdata", bus.readdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("t6_no_rdv", 32'(bus.readdatavalid), 32'd0);
            @(negedge clk);
        end
        $display("[TB] txn read 0x5000 abandoned by reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/avalon_ahb_bridge.md
Name: avalon_ahb_bridge

Overview:
Avalon-MM slave to AHB master bridge. Local Avalon masters (e.g. FPGA-side DMA or a test driver) reach AHB slaves on the system bus through it. It is the opposite direction of the AHB-slave/Avalon-master bridge. Only single 32-bit transfers are supported, with one outstanding transaction at a time; back-pressure to the Avalon side uses waitrequest and readdatavalid.

Parameters:
ERR_DATA, 32'hDEAD_BEEF, readdata value returned for a read that terminates with an AHB ERROR.
HPROT_VAL, 4'b0011, constant driven on HPROT (data access, privileged).
RETRY_LIMIT, 15, number of RETRY/SPLIT re-issues before the transfer is treated as ERROR.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset, sampled on posedge clk
address  in  32  Avalon byte address
read  in  1  Avalon read request
write  in  1  Avalon write request
writedata  in  32  Avalon write data
waitrequest  out  1  Avalon stall; low only in the accept cycle
readdatavalid  out  1  one-cycle read-data strobe
readdata  out  32  read data (valid with readdatavalid)
HADDR  out  32  AHB address
HTRANS  out  2  2'b00 IDLE / 2'b10 NONSEQ only
HWRITE  out  1  transfer direction
HSIZE  out  3  fixed 3'b010 (word)
HBURST  out  3  fixed 3'b000 (SINGLE)
HPROT  out  4  HPROT_VAL
HWDATA  out  32  write data, driven in data phase
HRDATA  in  32  AHB read data
HREADY  in  1  AHB transfer-done / phase advance
HRESP  in  2  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT
err_clr  in  1  clears err_sticky
err_sticky  out  1  set on any ERROR-terminated transfer

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n. While reset_n is low, waitrequest=1 (combinational override).
- Values after a reset edge: state IDLE, HTRANS=IDLE, HWRITE=0, HADDR=0, HWDATA=0, readdatavalid=0, readdata=0, err_sticky=0, retry count=0.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - waitrequest=0, HTRANS=IDLE.
  - If read or write is high, the command is accepted this cycle. It latches address, writedata and direction, then goes to ADDR.
  - If read and write are both high, the write wins.
- ADDR:
  - waitrequest=1, HTRANS=NONSEQ, HADDR=latched address, HWRITE=latched direction.
  - HREADY=1: go to DATA. HREADY=0: stay, holding all address-phase signals stable.
- DATA:
  - waitrequest=1, HTRANS=IDLE, HWDATA=latched writedata.
  - HREADY=0: stay. This covers wait states and the first cycle of a two-cycle response; HTRANS is already IDLE, so a two-cycle ERROR cancels nothing.
  - HREADY=1 with HRESP=OKAY: a write goes to IDLE; a read captures HRDATA into readdata and goes to RESP.
  - HREADY=1 with HRESP=ERROR: set err_sticky. A write goes to IDLE; a read loads ERR_DATA and goes to RESP.
  - HREADY=1 with HRESP=RETRY or SPLIT: increment the retry count and go back to ADDR to re-issue. When the count reaches RETRY_LIMIT, treat the transfer as ERROR instead.
  - The retry count clears on every accept.
- RESP:
  - readdatavalid=1 for exactly one cycle; readdata holds its value afterwards. Go to IDLE.
- Latency with zero-wait AHB, command accepted at edge T:
  - Address phase in T+1, data phase in T+2.
  - readdatavalid in T+3; the next accept is possible in T+4 (read) or T+3 (write).
- err_sticky: set has priority over err_clr when both occur in the same cycle.
- Reset mid-transfer: the pending transfer is abandoned. HTRANS=IDLE after the edge, and no readdatavalid is issued for the abandoned read.

Test Plan:
1. Write 0x1000 with data 0xCAFEF00D, HREADY always 1 -> waitrequest low one cycle; NONSEQ with HADDR=0x1000, HWRITE=1 next cycle; HWDATA=0xCAFEF00D the cycle after; back to IDLE.
2. Read 0x2004, slave inserts 3 wait states returning 0x12345678 -> readdatavalid a single pulse with readdata=0x12345678; waitrequest stays high until then.
3. Read with two-cycle ERROR response -> readdata=0xDEADBEEF, err_sticky=1; after an err_clr pulse, err_sticky=0.
4. Write answered RETRY twice, then OKAY -> HTRANS=NONSEQ re-issued exactly 2 extra times with the same HADDR/HWDATA; err_sticky=0.
5. RETRY answered forever -> after 15 re-issues the transfer ends as ERROR, err_sticky=1, bridge returns to IDLE.
6. reset_n low during DATA of a read -> HTRANS=IDLE after the edge, no readdatavalid, waitrequest=0 once reset_n is released.
